// File: rtl/rf_wb_serializer_if.sv
// Write-back request channels, RAM write port and queue status for rf_wb_serializer.
// Handshake: a channel transfers on a posedge where valid & ready are both 1; ready never depends on valid.
interface rf_wb_serializer_if #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int NADDR = 1 << ADDR_W;

    logic              wr0_valid;
    logic              wr0_ready;
    logic [ADDR_W-1:0] wr0_addr;
    logic [WIDTH-1:0]  wr0_data;
    logic              wr1_valid;
    logic              wr1_ready;
    logic [ADDR_W-1:0] wr1_addr;
    logic [WIDTH-1:0]  wr1_data;
    logic              ram_wea;
    logic [ADDR_W-1:0] ram_addrw;
    logic [WIDTH-1:0]  ram_din;
    logic [NADDR-1:0]  pend_mask;
    logic [CNT_W-1:0]  q_count;

    modport master (
        output wr0_valid, wr0_addr, wr0_data,
        output wr1_valid, wr1_addr, wr1_data,
        input  wr0_ready, wr1_ready,
        input  ram_wea, ram_addrw, ram_din, pend_mask, q_count
    );

    modport slave (
        input  wr0_valid, wr0_addr, wr0_data,
        input  wr1_valid, wr1_addr, wr1_data,
        output wr0_ready, wr1_ready,
        output ram_wea, ram_addrw, ram_din, pend_mask, q_count
    );
endinterface

// File: rtl/rf_wb_serializer.sv
// Two-channel write-back queue draining one write per cycle into a single RAM write port.
// Optional macro WB_BYPASS_EN: an empty queue lets wr0 drive the RAM port in its accept cycle.
module rf_wb_serializer #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 4
) (
    input logic               clk,
    input logic               rst,
    rf_wb_serializer_if.slave wb
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NADDR = 1 << ADDR_W;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [WIDTH-1:0]  data_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  slot1;
    logic [PTR_W-1:0]  off;
    logic [NADDR-1:0]  pend;
    logic              acc0, acc1, push0, push1, pop, byp;

    // Readiness comes from registered occupancy only; the same-cycle drain is not credited.
    assign wb.wr0_ready = (count_q <= CNT_W'(DEPTH - 1));
    assign wb.wr1_ready = (count_q <= CNT_W'(DEPTH - 2));

    assign acc0 = wb.wr0_valid & wb.wr0_ready;
    assign acc1 = wb.wr1_valid & wb.wr1_ready;
    assign pop  = (count_q != '0);

`ifdef WB_BYPASS_EN
    assign byp = acc0 & ~pop & ~rst;
`else
    assign byp = 1'b0;
`endif

    assign push0 = acc0 & ~byp;
    assign push1 = acc1;
    // wr1 lands behind wr0 when both push, otherwise in the first free slot.
    assign slot1 = wr_ptr_q + PTR_W'(push0);

    assign rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    assign wr_ptr_d = wr_ptr_q + PTR_W'(push0) + PTR_W'(push1);
    assign count_d  = count_q + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);

    always_comb begin
        wb.ram_wea   = pop;
        wb.ram_addrw = addr_q[rd_ptr_q];
        wb.ram_din   = data_q[rd_ptr_q];
        if (byp) begin
            wb.ram_wea   = 1'b1;
            wb.ram_addrw = wb.wr0_addr;
            wb.ram_din   = wb.wr0_data;
        end
    end

    // An entry is live when its distance from the head is below the occupancy.
    always_comb begin
        pend = '0;
        off  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PTR_W'(i) - rd_ptr_q;
            if ({1'b0, off} < count_q) begin
                pend[addr_q[i]] = 1'b1;
            end
        end
    end

    assign wb.pend_mask = pend;
    assign wb.q_count   = count_q;

    always_ff @(posedge clk) begin
        if (push0) begin
            addr_q[wr_ptr_q] <= wb.wr0_addr;
            data_q[wr_ptr_q] <= wb.wr0_data;
        end
        if (push1) begin
            addr_q[slot1] <= wb.wr1_addr;
            data_q[slot1] <= wb.wr1_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    count_bound_a: assert property (@(posedge clk) disable iff (rst) count_q <= CNT_W'(DEPTH));
endmodule
